regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DROP_R0, default 1: when 1, writes that target register 0 are accepted but never issued.
REQ-002 Port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port hold, input, 1: pipeline stall; while high, no request is granted.
REQ-005 Port req_valid, input, 3: bit i high means requester i (0=ALU, 1=load, 2=multdiv) presents a write.
REQ-006 Port req_reg, input, 15: destination register of requester i, in bits [5i+4:5i].
REQ-007 Port req_data, input, 96: write data of requester i, in bits [32i+31:32i].
REQ-008 Port req_ready, output, 3: bit i high means requester i is granted this cycle; combinational.
REQ-009 Port ctrl_writeEnable, output, 1: registered write enable to the register file.
REQ-010 Port ctrl_writeReg, output, 5: registered destination register to the register file.
REQ-011 Port data_writeReg, output, 32: registered write data to the register file.
REQ-012 Port busy_mask, output, 32: bit n high while the issued write targets register n.
REQ-013 Port grant_id, output, 2: registered index of the last accepted requester; 3 means none.

Function
REQ-014 A transfer from requester i occurs in a cycle when req_valid[i] and req_ready[i] are both high at the rising clock edge.
REQ-015 At most one req_ready bit is high per cycle.
REQ-016 All req_ready bits are 0 when hold=1 or req_valid=0.
REQ-017 Otherwise, req_ready goes to the first valid requester, searching upward from priority pointer ptr with wrap-around 2->0.
REQ-018 ptr is a 2-bit state with legal values 0..2.
REQ-019 After a transfer from requester i, ptr becomes (i+1) mod 3; with no transfer, ptr is unchanged.
REQ-020 Latency is 1 cycle: a transfer at edge k drives ctrl_writeReg/data_writeReg from the winning requester and ctrl_writeEnable=1 during cycle k+1.
REQ-021 ctrl_writeEnable is 1 for exactly one cycle per transfer; a cycle with no transfer gives ctrl_writeEnable=0 in the next cycle.
REQ-022 ctrl_writeReg and data_writeReg hold their previous values when ctrl_writeEnable=0.
REQ-023 Back-to-back transfers on consecutive edges are supported with no bubble; the output stage never stalls.
REQ-024 DROP_R0=1 and winning req_reg=0: the transfer completes, ptr advances and grant_id updates, but the next-cycle ctrl_writeEnable=0.
REQ-025 DROP_R0=0: register 0 writes are issued like any other.
REQ-026 busy_mask is the one-hot decode of ctrl_writeReg when ctrl_writeEnable=1, and all-zero otherwise.
REQ-027 Two or more requesters naming the same register in one cycle are serialized in round-robin order; the later write is issued in a later cycle and overwrites the earlier one.
REQ-028 Fairness: with hold=0, a continuously valid requester is granted within 3 cycles of asserting valid.
REQ-029 hold rising while a request is already issued does not cancel the issued write; only new grants are blocked.
REQ-030 Requesters hold req_reg/req_data stable while valid and not ready; the arbiter samples them only on the transfer edge.

Reset
REQ-031 While reset=1, the block immediately forces ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, busy_mask=0, grant_id=3 and ptr=0, independent of clock.
REQ-032 req_ready is 0 while reset=1.
REQ-033 A write accepted in the edge before reset asserts is discarded and never issued.
REQ-034 The first edge after reset deasserts uses normal arbitration with ptr=0.

Verification
REQ-035 Reset, then req_valid=3'b111 with reg 1/2/3 for 4 cycles -> req_ready sequence 001,010,100,001; writes issued to regs 1,2,3,1 on the following cycles, each with its own data.
REQ-036 req_valid=3'b010, reg 5, data 0xDEADBEEF for 1 cycle -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF, busy_mask=0x00000020, grant_id=1; the cycle after that ctrl_writeEnable=0 and busy_mask=0.
REQ-037 DROP_R0=1, requester 0 writes reg 0 -> req_ready[0]=1, next cycle ctrl_writeEnable=0 and grant_id=0; with DROP_R0=0 -> ctrl_writeEnable=1, ctrl_writeReg=0.
REQ-038 hold=1 for 3 cycles with req_valid=3'b101 -> req_ready=0 and no writes issued; hold drops -> requester 0 is granted, then requester 2.
REQ-039 Grant requester 2 (reg 7), then assert reset mid-cycle before the next edge -> outputs go to zero immediately, the reg 7 write never appears, and after release the first grant goes to requester 0.
REQ-040 Requesters 0 and 1 both target reg 9 with data 0x1 and 0x2, ptr=0 -> writes are issued in order 0x1 then 0x2 on consecutive cycles.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: three requesters (ALU, load, multdiv)
// share one write port. Round-robin grant, one-cycle registered issue stage.

// Per-requester slice: unpacks the flat request buses and decides whether
// a write from this lane is actually issued (register 0 may be dropped).
module regfile_write_arbiter_lane #(
  parameter int DROP_R0 = 1
) (
  input  logic        valid,
  input  logic [4:0]  rd_in,
  input  logic [31:0] data_in,
  output logic        cand,
  output logic        issue_ok,
  output logic [4:0]  rd_out,
  output logic [31:0] data_out
);
  assign cand     = valid;
  assign issue_ok = !((DROP_R0 != 0) && (rd_in == 5'd0));
  assign rd_out   = rd_in;
  assign data_out = data_in;
endmodule

module regfile_write_arbiter #(
  parameter int DROP_R0 = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_reg,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] busy_mask,
  output logic [1:0]  grant_id
);
  localparam int NUM_REQ = 3;
  localparam int RW      = 5;
  localparam int DW      = 32;
  localparam int STAGES  = 0;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          wr;
  } wr_req_t;

  logic [NUM_REQ-1:0]         cand;
  logic [NUM_REQ-1:0]         issue_ok;
  logic [NUM_REQ-1:0][RW-1:0] lane_rd;
  logic [NUM_REQ-1:0][DW-1:0] lane_data;

  logic [1:0]        ptr;
  logic [2:0]        idx;
  logic              found;
  logic [1:0]        win;
  logic              grant;
  wr_req_t           nxt;
  logic [STAGES:0]   vld_pipe;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    regfile_write_arbiter_lane #(.DROP_R0(DROP_R0)) u_lane (
      .valid    (req_valid[g]),
      .rd_in    (req_reg[RW*g +: RW]),
      .data_in  (req_data[DW*g +: DW]),
      .cand     (cand[g]),
      .issue_ok (issue_ok[g]),
      .rd_out   (lane_rd[g]),
      .data_out (lane_data[g])
    );
  end

  // Round-robin search: first valid lane at or after ptr, wrapping 2->0.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      if (!found && cand[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  assign grant = found && !hold && !reset;

  // One-hot ready to the winner; nothing while stalled or in reset.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  assign nxt.rd   = lane_rd[win];
  assign nxt.data = lane_data[win];
  assign nxt.wr   = issue_ok[win];

  // Issue stage: a dropped r0 write still advances ptr/grant_id but leaves
  // the register-file outputs untouched and write enable low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr           <= 2'd0;
      grant_id      <= 2'd3;
      vld_pipe      <= '0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
    end else begin
      vld_pipe[0] <= grant && nxt.wr;
      if (grant) begin
        ptr      <= (win == 2'(NUM_REQ-1)) ? 2'd0 : win + 2'd1;
        grant_id <= win;
        if (nxt.wr) begin
          ctrl_writeReg <= nxt.rd;
          data_writeReg <= nxt.data;
        end
      end
    end
  end

  assign ctrl_writeEnable = vld_pipe[STAGES];
  assign busy_mask        = ctrl_writeEnable ? (32'd1 << ctrl_writeReg) : 32'd0;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench: two instances (DROP_R0=1 and DROP_R0=0) on shared inputs, checked
// every cycle against a round-robin model, plus fixed directed scenarios.
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hold  = 1'b0;
  logic [2:0]       req_valid = '0;
  logic [2:0][4:0]  t_reg  = '0;
  logic [2:0][31:0] t_data = '0;

  logic [2:0]  rdy_o  [2];
  logic        we_o   [2];
  logic [4:0]  wreg_o [2];
  logic [31:0] wdat_o [2];
  logic [31:0] busy_o [2];
  logic [1:0]  gid_o  [2];

  int checks = 0;
  int errors = 0;

  // model state (reset values)
  int          mptr = 0;
  int          mgid = 3;
  bit          mwe  [2] = '{0, 0};
  logic [4:0]  mreg [2] = '{0, 0};
  logic [31:0] mdat [2] = '{0, 0};

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DROP_R0(1)) u_drop (
    .clock(clock), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_reg(t_reg), .req_data(t_data), .req_ready(rdy_o[0]),
    .ctrl_writeEnable(we_o[0]), .ctrl_writeReg(wreg_o[0]),
    .data_writeReg(wdat_o[0]), .busy_mask(busy_o[0]), .grant_id(gid_o[0]));

  regfile_write_arbiter #(.DROP_R0(0)) u_keep (
    .clock(clock), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_reg(t_reg), .req_data(t_data), .req_ready(rdy_o[1]),
    .ctrl_writeEnable(we_o[1]), .ctrl_writeReg(wreg_o[1]),
    .data_writeReg(wdat_o[1]), .busy_mask(busy_o[1]), .grant_id(gid_o[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Granted requester this cycle, or -1.
  function automatic int winner();
    if (reset || hold) return -1;
    for (int k = 0; k < 3; k++) begin
      int i = (mptr + k) % 3;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    int w = winner();
    return (w < 0) ? 3'b000 : 3'(1 << w);
  endfunction

  task automatic model_reset();
    mptr = 0; mgid = 3;
    for (int d = 0; d < 2; d++) begin mwe[d] = 0; mreg[d] = '0; mdat[d] = '0; end
  endtask

  // Called right at a rising edge with the inputs the DUT just sampled.
  task automatic model_step();
    int w;
    if (reset) return;
    w = winner();
    for (int d = 0; d < 2; d++) mwe[d] = 0;
    if (w >= 0) begin
      mptr = (w + 1) % 3;
      mgid = w;
      for (int d = 0; d < 2; d++) begin
        if (!(d == 0 && t_reg[w] == 5'd0)) begin
          mwe[d] = 1; mreg[d] = t_reg[w]; mdat[d] = t_data[w];
        end
      end
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ready[%0d]", d), 64'(rdy_o[d]), 64'(exp_ready()));
      chk($sformatf("we[%0d]", d),    64'(we_o[d]),  64'(mwe[d]));
      chk($sformatf("wreg[%0d]", d),  64'(wreg_o[d]), 64'(mreg[d]));
      chk($sformatf("wdata[%0d]", d), 64'(wdat_o[d]), 64'(mdat[d]));
      chk($sformatf("busy[%0d]", d),  64'(busy_o[d]), mwe[d] ? 64'(32'd1 << mreg[d]) : 64'd0);
      chk($sformatf("gid[%0d]", d),   64'(gid_o[d]), 64'(mgid));
    end
  end

  // One cycle: edge, model update, drive new inputs, return after negedge.
  task automatic cyc(input logic h, input logic [2:0] v,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    @(posedge clock);
    model_step();
    #1;
    hold = h; req_valid = v;
    t_reg[0] = r0; t_reg[1] = r1; t_reg[2] = r2;
    t_data[0] = d0; t_data[1] = d1; t_data[2] = d2;
    @(negedge clock);
    #1;
  endtask

  logic [2:0] seq_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [4:0] seq_reg [4] = '{5'd1, 5'd2, 5'd3, 5'd1};
  logic [31:0] seq_dat [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA0};

  initial begin
    // reset state
    @(negedge clock); #1;
    chk("rst_we", 64'(we_o[0]), 64'd0);
    chk("rst_gid", 64'(gid_o[0]), 64'd3);
    chk("rst_ready", 64'(rdy_o[0]), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); #1;

    // round robin with all three valid
    for (int k = 0; k < 4; k++) begin
      cyc(0, 3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
      chk("rr_ready", 64'(rdy_o[0]), 64'(seq_rdy[k]));
      if (k > 0) begin
        chk("rr_reg", 64'(wreg_o[0]), 64'(seq_reg[k-1]));
        chk("rr_data", 64'(wdat_o[0]), 64'(seq_dat[k-1]));
      end
    end
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("rr_last_reg", 64'(wreg_o[0]), 64'd1);
    chk("rr_last_we", 64'(we_o[0]), 64'd1);

    // single write from requester 1 (ptr is now 1)
    cyc(0, 3'b010, 0, 5'd5, 0, 0, 32'hDEADBEEF, 0);
    chk("s_ready", 64'(rdy_o[0]), 64'b010);
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("s_we", 64'(we_o[0]), 64'd1);
    chk("s_reg", 64'(wreg_o[0]), 64'd5);
    chk("s_data", 64'(wdat_o[0]), 64'hDEADBEEF);
    chk("s_busy", 64'(busy_o[0]), 64'h20);
    chk("s_gid", 64'(gid_o[0]), 64'd1);
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("s_we_off", 64'(we_o[0]), 64'd0);
    chk("s_busy_off", 64'(busy_o[0]), 64'd0);
    chk("s_reg_hold", 64'(wreg_o[0]), 64'd5);

    // register 0 write: dropped on u_drop, issued on u_keep
    cyc(0, 3'b001, 5'd0, 0, 0, 32'h55, 0, 0);
    chk("r0_ready", 64'(rdy_o[0]), 64'b001);
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("r0_drop_we", 64'(we_o[0]), 64'd0);
    chk("r0_drop_gid", 64'(gid_o[0]), 64'd0);
    chk("r0_drop_reg", 64'(wreg_o[0]), 64'd5);
    chk("r0_keep_we", 64'(we_o[1]), 64'd1);
    chk("r0_keep_reg", 64'(wreg_o[1]), 64'd0);

    // move ptr to 0, then same-register collision
    cyc(0, 3'b100, 0, 0, 5'd4, 0, 0, 32'h4);
    cyc(0, 3'b011, 5'd9, 5'd9, 0, 32'h1, 32'h2, 0);
    chk("col_ready0", 64'(rdy_o[0]), 64'b001);
    cyc(0, 3'b010, 0, 5'd9, 0, 0, 32'h2, 0);
    chk("col_ready1", 64'(rdy_o[0]), 64'b010);
    chk("col_data1", 64'(wdat_o[0]), 64'h1);
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("col_data2", 64'(wdat_o[0]), 64'h2);
    chk("col_reg2", 64'(wreg_o[0]), 64'd9);

    // ptr is 2: grant requester 2 to bring it back to 0, then hold
    cyc(0, 3'b100, 0, 0, 5'd6, 0, 0, 32'h6);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 3'b101, 5'd10, 0, 5'd12, 32'h10, 0, 32'h12);
      chk("hold_ready", 64'(rdy_o[0]), 64'd0);
      if (k > 0) chk("hold_we", 64'(we_o[0]), 64'd0);
    end
    cyc(0, 3'b101, 5'd10, 0, 5'd12, 32'h10, 0, 32'h12);
    chk("hold_rel0", 64'(rdy_o[0]), 64'b001);
    cyc(0, 3'b100, 0, 0, 5'd12, 0, 0, 32'h12);
    chk("hold_rel2", 64'(rdy_o[0]), 64'b100);
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0);

    // grant requester 2 (reg 7), reset mid-cycle before it would issue
    cyc(0, 3'b100, 0, 0, 5'd7, 0, 0, 32'h77);
    chk("mr_ready", 64'(rdy_o[0]), 64'b100);
    @(posedge clock);
    model_step();
    #2;
    reset = 1'b1;
    model_reset();
    req_valid = 3'b111; t_reg[0] = 5'd1; t_reg[1] = 5'd2; t_reg[2] = 5'd3;
    #1;
    chk("mr_we", 64'(we_o[0]), 64'd0);
    chk("mr_reg", 64'(wreg_o[0]), 64'd0);
    chk("mr_busy", 64'(busy_o[0]), 64'd0);
    chk("mr_gid", 64'(gid_o[0]), 64'd3);
    @(posedge clock);
    model_step();
    #2 reset = 1'b0;
    @(negedge clock); #1;
    chk("mr_first", 64'(rdy_o[0]), 64'b001);
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("mr_first_reg", 64'(wreg_o[0]), 64'd1);

    // randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 600; n++) begin
      @(posedge clock);
      model_step();
      #1;
      if (reset) reset = 1'b0;
      hold = ($urandom_range(0, 4) == 0);
      req_valid = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        t_reg[i]  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        t_data[i] = $urandom;
      end
      if ($urandom_range(0, 63) == 0) begin
        #1 reset = 1'b1;
        model_reset();
      end
    end
    @(posedge clock);
    model_step();
    #1 req_valid = '0; reset = 1'b0;
    @(negedge clock); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
